// File: rtl/snake_pkg.sv
// Shared snake rendering definitions: screen geometry, default grid sizing,
// the cell_painter state encoding and a constant-math helper.
package snake_pkg;

   localparam int       SCREEN_W      = 160;
   localparam int       SCREEN_H      = 120;
   localparam logic [2:0] COLOUR_BLACK = 3'b000;

   localparam int CELL_SIZE_DEF = 4;
   localparam int GRID_W_DEF    = 40;
   localparam int GRID_H_DEF    = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } cp_state_t;

   // Ceiling log2 for elaboration-time width math (cp_clog2(1) == 0).
   function automatic int cp_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int cp_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major px/py scan over one CELL_SIZE x CELL_SIZE cell.
// Advances only when enabled, so back-pressure simply freezes the scan.
module cell_scan_counter
   import snake_pkg::*;
#(
   parameter int CELL_SIZE = CELL_SIZE_DEF,
   parameter int CW        = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          en_i,
   output logic [CW-1:0] px_o,
   output logic [CW-1:0] py_o,
   output logic          last_o
);

   localparam logic [CW-1:0] PMAX = CW'(CELL_SIZE - 1);

   logic [CW-1:0] px_q, py_q;

   // px runs fastest; wrapping px steps py, wrapping both returns to origin.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         px_q <= '0;
         py_q <= '0;
      end else if (en_i) begin
         if (px_q == PMAX) begin
            px_q <= '0;
            py_q <= (py_q == PMAX) ? '0 : py_q + 1'b1;
         end else begin
            px_q <= px_q + 1'b1;
         end
      end
   end

   assign px_o   = px_q;
   assign py_o   = py_q;
   assign last_o = (px_q == PMAX) && (py_q == PMAX);

endmodule

// File: rtl/cell_painter.sv
// Paints one grid cell as CELL_SIZE^2 single-pixel writes toward the
// draw/erase arbiter. Optional macro CELL_PAINTER_CLIP_EN suppresses writes
// whose untruncated coordinate falls off the 160x120 screen.
module cell_painter
   import snake_pkg::*;
#(
   parameter int CELL_SIZE = CELL_SIZE_DEF,
   parameter int GRID_W    = GRID_W_DEF,
   parameter int GRID_H    = GRID_H_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] cell_x,
   input  logic [4:0] cell_y,
   input  logic [2:0] colour_in,
   input  logic       hold,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic       wren,
   output logic       busy,
   output logic       done
);

   localparam int SH = cp_clog2(CELL_SIZE);
   localparam int CW = (SH > 0) ? SH : 1;
   // Internal sums wide enough for any 6-bit/5-bit cell index (and for the
   // configured grid) so the clip test sees the true coordinate.
   localparam int XW = cp_max(9, cp_clog2(GRID_W * CELL_SIZE) + 1);
   localparam int YW = cp_max(8, cp_clog2(GRID_H * CELL_SIZE) + 1);

   cp_state_t     state_q;
   logic [XW-1:0] ox_q, ox_d;
   logic [YW-1:0] oy_q, oy_d;
   logic [2:0]    col_q;
   logic [CW-1:0] px, py;
   logic          last_px;
   logic          in_draw, step, clip_ok;
   logic [XW-1:0] x_sum;
   logic [YW-1:0] y_sum;

   assign ox_d    = XW'(cell_x) << SH;
   assign oy_d    = YW'(cell_y) << SH;
   assign in_draw = (state_q == ST_DRAW);
   assign step    = in_draw && !hold;

   cell_scan_counter #(.CELL_SIZE(CELL_SIZE), .CW(CW)) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clear_i(!in_draw),
      .en_i   (step),
      .px_o   (px),
      .py_o   (py),
      .last_o (last_px)
   );

   // Request latch and IDLE -> DRAW -> DONE sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ox_q    <= '0;
         oy_q    <= '0;
         col_q   <= COLOUR_BLACK;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               ox_q    <= ox_d;
               oy_q    <= oy_d;
               col_q   <= colour_in;
               state_q <= ST_DRAW;
            end
            ST_DRAW: if (step && last_px) state_q <= ST_DONE;
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign x_sum = ox_q + XW'(px);
   assign y_sum = oy_q + YW'(py);

`ifdef CELL_PAINTER_CLIP_EN
   assign clip_ok = (x_sum < XW'(SCREEN_W)) && (y_sum < YW'(SCREEN_H));
`else
   assign clip_ok = 1'b1;
`endif

   assign x_out      = in_draw ? x_sum[7:0] : 8'd0;
   assign y_out      = in_draw ? y_sum[6:0] : 7'd0;
   assign colour_out = in_draw ? col_q : COLOUR_BLACK;
   assign wren       = step && clip_ok;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);

endmodule
